// File: rtl/text_arb_pkg.sv
// text_arb_pkg: shared types and helpers for the text memory arbiter.
package text_arb_pkg;
  typedef enum logic {PRIO_FETCH, PRIO_DATA} prio_t;
  typedef enum logic [1:0] {RESP_NONE, RESP_FETCH, RESP_DATA} resp_sel_t;
  localparam int GNT_FETCH = 0;
  localparam int GNT_DATA = 1;
  function automatic resp_sel_t resp_of(input logic [1:0] gnt);
    return gnt[GNT_FETCH] ? RESP_FETCH : gnt[GNT_DATA] ? RESP_DATA : RESP_NONE;
  endfunction
endpackage

// File: rtl/text_rr_arbiter.sv
// text_rr_arbiter: two-port round-robin grant with next-priority computation.
module text_rr_arbiter
  import text_arb_pkg::*;
(
  input  logic       fetch_req,
  input  logic       data_req,
  input  prio_t      prio,
  output logic [1:0] gnt,
  output prio_t      prio_nxt
);
  always_comb begin
    gnt[GNT_FETCH] = fetch_req & (~data_req | (prio == PRIO_FETCH));
    gnt[GNT_DATA]  = data_req & (~fetch_req | (prio == PRIO_DATA));
    prio_nxt = gnt[GNT_FETCH] ? PRIO_DATA : gnt[GNT_DATA] ? PRIO_FETCH : prio;
  end
endmodule

// File: rtl/text_memory_arbiter.sv
// text_memory_arbiter: single-port text memory shared by fetch and data reads.
// Optional LOADER_EN adds a write-only load port with absolute priority.
`ifndef TEXT_BITS
`define TEXT_BITS 14
`endif
module text_memory_arbiter
  import text_arb_pkg::*;
#(
  parameter int ADDR_W = `TEXT_BITS - 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [31:0]       data_rdata,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [31:0]       mem_q,
  output logic              mem_wren,
  output logic [31:0]       mem_wdata
`ifdef LOADER_EN
  ,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              load_gnt
`endif
);
  logic [1:0] gnt;
  prio_t prio, prio_nxt;
  resp_sel_t resp_sel;
  logic ld;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0] ld_data;
`ifdef LOADER_EN
  assign ld = load_req;
  assign ld_addr = load_addr;
  assign ld_data = load_data;
  assign load_gnt = ld & reset_n;
`else
  assign ld = 1'b0;
  assign ld_addr = '0;
  assign ld_data = '0;
`endif
  // Reads are masked during a load so prio holds and no response is queued.
  text_rr_arbiter u_rr (
    .fetch_req(fetch_req & ~ld),
    .data_req (data_req & ~ld),
    .prio     (prio),
    .gnt      (gnt),
    .prio_nxt (prio_nxt)
  );
  assign fetch_gnt = gnt[GNT_FETCH] & reset_n;
  assign data_gnt = gnt[GNT_DATA] & reset_n;
  assign mem_address = ld ? ld_addr : gnt[GNT_DATA] ? data_addr : fetch_addr;
  assign mem_wren = ld & reset_n;
  assign mem_wdata = mem_wren ? ld_data : '0;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio <= PRIO_FETCH;
      resp_sel <= RESP_NONE;
    end else begin
      prio <= prio_nxt;
      resp_sel <= resp_of(gnt);
    end
  end
  assign fetch_rvalid = (resp_sel == RESP_FETCH);
  assign data_rvalid = (resp_sel == RESP_DATA);
  assign fetch_rdata = fetch_rvalid ? mem_q : '0;
  assign data_rdata = data_rvalid ? mem_q : '0;
endmodule

// File: tb/tb_text_memory_arbiter.sv
// tb_text_memory_arbiter: directed scoreboard bench with a synchronous memory model.
module tb_text_memory_arbiter;
  localparam int AW = 12;
  typedef struct {logic port; logic [31:0] data;} exp_t;
  logic clock, reset_n;
  logic fetch_req, data_req, fetch_gnt, data_gnt, fetch_rvalid, data_rvalid, mem_wren;
  logic [AW-1:0] fetch_addr, data_addr, mem_address;
  logic [31:0] fetch_rdata, data_rdata, mem_q, mem_wdata;
`ifdef LOADER_EN
  logic load_req, load_gnt;
  logic [AW-1:0] load_addr;
  logic [31:0] load_data;
`endif
  logic [31:0] mem [2**AW];
  logic [31:0] model [2**AW];
  exp_t q[$];
  int total = 0;
  int bad = 0;
  text_memory_arbiter #(.ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_address(mem_address), .mem_q(mem_q), .mem_wren(mem_wren), .mem_wdata(mem_wdata)
`ifdef LOADER_EN
    , .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_gnt(load_gnt)
`endif
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (mem_wren) mem[mem_address] <= mem_wdata;
    mem_q <= mem[mem_address];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // One cycle: check grants and due responses, queue expected reads, advance.
  task automatic cyc(input string tag, input logic ef, input logic ed);
    exp_t e;
    #1;
    chk({tag, ".fetch_gnt"}, {31'd0, fetch_gnt}, {31'd0, ef});
    chk({tag, ".data_gnt"}, {31'd0, data_gnt}, {31'd0, ed});
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, ".fetch_rvalid"}, {31'd0, fetch_rvalid}, {31'd0, ~e.port});
      chk({tag, ".data_rvalid"}, {31'd0, data_rvalid}, {31'd0, e.port});
      chk({tag, ".rdata"}, e.port ? data_rdata : fetch_rdata, e.data);
      chk({tag, ".idle_rdata"}, e.port ? fetch_rdata : data_rdata, 32'd0);
    end else begin
      chk({tag, ".no_rvalid"}, {30'd0, fetch_rvalid, data_rvalid}, 32'd0);
      chk({tag, ".no_rdata"}, fetch_rdata | data_rdata, 32'd0);
    end
    if (ef) q.push_back('{1'b0, model[fetch_addr]});
    if (ed) q.push_back('{1'b1, model[data_addr]});
    @(negedge clock);
  endtask
  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = (i * 32'h01010101) ^ 32'hA5000000;
      model[i] = (i * 32'h01010101) ^ 32'hA5000000;
    end
    reset_n = 1'b0;
    fetch_req = 1'b1; data_req = 1'b1;
    fetch_addr = 12'h004; data_addr = 12'h008;
`ifdef LOADER_EN
    load_req = 1'b0; load_addr = '0; load_data = '0;
`endif
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("rst.gnt", {30'd0, fetch_gnt, data_gnt}, 32'd0);
    chk("rst.rvalid", {30'd0, fetch_rvalid, data_rvalid}, 32'd0);
    chk("rst.rdata", fetch_rdata | data_rdata, 32'd0);
    chk("rst.wren", {31'd0, mem_wren}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1; fetch_req = 1'b0; data_req = 1'b0;
    cyc("idle0", 1'b0, 1'b0);
    fetch_req = 1'b1; fetch_addr = 12'h010;
    cyc("single_fetch", 1'b1, 1'b0);
    fetch_req = 1'b0;
    cyc("single_fetch_resp", 1'b0, 1'b0);
    // prio now DATA; four data-only grants flip it back to FETCH
    data_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_addr = AW'(i);
      cyc("data_burst", 1'b0, 1'b1);
    end
    data_req = 1'b0;
    cyc("data_burst_drain", 1'b0, 1'b0);
    fetch_req = 1'b1; data_req = 1'b1; fetch_addr = 12'h004; data_addr = 12'h008;
    for (int i = 0; i < 6; i++) cyc("contend", (i % 2) == 0, (i % 2) == 1);
    fetch_req = 1'b0; data_req = 1'b0;
    cyc("contend_drain", 1'b0, 1'b0);
    fetch_req = 1'b1; fetch_addr = 12'h033;
    cyc("pre_idle_fetch", 1'b1, 1'b0);
    fetch_req = 1'b0;
    for (int i = 0; i < 5; i++) cyc("idle5", 1'b0, 1'b0);
    fetch_req = 1'b1; data_req = 1'b1; fetch_addr = 12'h040; data_addr = 12'h041;
    cyc("prio_held", 1'b0, 1'b1);
    fetch_req = 1'b0; data_req = 1'b0;
    cyc("prio_held_drain", 1'b0, 1'b0);
    fetch_req = 1'b1; fetch_addr = 12'h055;
    cyc("pre_reset_fetch", 1'b1, 1'b0);
    reset_n = 1'b0; fetch_req = 1'b0;
    #1;
    chk("reset_kill.fetch_rvalid", {31'd0, fetch_rvalid}, 32'd0);
    chk("reset_kill.fetch_rdata", fetch_rdata, 32'd0);
    q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    cyc("post_reset0", 1'b0, 1'b0);
    cyc("post_reset1", 1'b0, 1'b0);
    fetch_req = 1'b1; data_req = 1'b1; fetch_addr = 12'h060; data_addr = 12'h061;
    cyc("post_reset_contend", 1'b1, 1'b0);
    fetch_req = 1'b0; data_req = 1'b0;
    cyc("post_reset_drain", 1'b0, 1'b0);
`ifdef LOADER_EN
    load_req = 1'b1; load_addr = 12'h020; load_data = 32'hDEADBEEF;
    fetch_req = 1'b1; fetch_addr = 12'h020;
    #1;
    chk("load.gnt", {31'd0, load_gnt}, 32'd1);
    chk("load.wren", {31'd0, mem_wren}, 32'd1);
    chk("load.wdata", mem_wdata, 32'hDEADBEEF);
    chk("load.addr", {20'd0, mem_address}, 32'h020);
    model[12'h020] = 32'hDEADBEEF;
    cyc("load", 1'b0, 1'b0);
    load_req = 1'b0;
    cyc("load_then_fetch", 1'b1, 1'b0);
    fetch_req = 1'b0;
    cyc("load_fetch_resp", 1'b0, 1'b0);
`endif
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/text_memory_arbiter.md
TEXT_MEMORY_ARBITER -- requirements
Module: text_memory_arbiter

Interface
REQ-001 Parameter: ADDR_W, default `TEXT_BITS-2, word-address width of the text memory.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 fetch_req  input  1  instruction-fetch read request.
REQ-005 fetch_addr  input  ADDR_W  fetch word address.
REQ-006 fetch_gnt  output  1  fetch request accepted this cycle.
REQ-007 fetch_rvalid  output  1  fetch read data valid.
REQ-008 fetch_rdata  output  32  fetch read data.
REQ-009 data_req, data_addr, data_gnt, data_rvalid, data_rdata  same directions and widths as REQ-004..008; data-side read of the text segment.
REQ-010 mem_address  output  ADDR_W  word address to the text memory.
REQ-011 mem_q  input  32  text memory read data, valid the cycle after mem_address is sampled.
REQ-012 mem_wren  output  1  text memory write enable.
REQ-013 mem_wdata  output  32  text memory write data.
REQ-014 load_req, load_addr (ADDR_W), load_data (32) inputs; load_gnt output 1; present only under LOADER_EN.

Function
REQ-015 The block SHALL grant at most one access per cycle; gnt is combinational from req in the same cycle.
REQ-016 A requester SHALL hold req and addr stable until granted; the block SHALL NOT depend on this holding after the grant.
REQ-017 mem_address SHALL equal the granted requester's address; with no grant it SHALL equal fetch_addr.
REQ-018 A granted read SHALL produce rvalid on that port for exactly one cycle, the cycle after the grant, with rdata = mem_q; rdata SHALL be 0 whenever rvalid is 0.
REQ-019 Throughput SHALL be one grant per cycle; back-to-back grants to the same port or to alternating ports are allowed.
REQ-020 A prio register {FETCH, DATA} SHALL select the winner when both ports request; if only one port requests, that port is granted.
REQ-021 On any read grant, prio SHALL switch to the non-granted port; without a read grant, prio SHALL hold.
REQ-022 Under continuous contention, neither port SHALL wait more than one cycle.
REQ-023 A response register resp_sel {NONE, FETCH, DATA} SHALL load the granted read port each cycle (NONE without a read grant) and drive the rvalids.
REQ-024 mem_wren SHALL be 0 except on load grants.

Reset
REQ-025 While reset_n is low, SHALL hold: all gnt and rvalid outputs 0, all rdata 0, prio = FETCH, resp_sel = NONE, mem_wren = 0.
REQ-026 A reset asserted while a response is outstanding SHALL discard that response; no rvalid SHALL follow reset release.

Configuration
REQ-027 Macro LOADER_EN: when defined, the load port exists and has absolute priority; a load grant SHALL drive mem_address = load_addr, mem_wdata = load_data and mem_wren = 1 for that cycle, with no rvalid, both read gnts 0, and prio unchanged.
REQ-028 When LOADER_EN is undefined, the load_* ports SHALL be absent, mem_wren SHALL be tied to 0 and mem_wdata to 0.

Structure
REQ-029 The package text_arb_pkg SHALL hold typedef prio_t {PRIO_FETCH, PRIO_DATA} and typedef resp_sel_t {RESP_NONE, RESP_FETCH, RESP_DATA}.
REQ-030 The two-port round-robin decision SHALL be a sub-module text_rr_arbiter (inputs: req pair, prio; outputs: one-hot grant, next prio).

Verification
REQ-031 Single fetch at 0x010 after reset -> fetch_gnt=1 in the same cycle; next cycle fetch_rvalid=1, fetch_rdata=mem[0x010], data_rvalid=0.
REQ-032 Both ports request continuously (fetch 0x004, data 0x008) -> grants F,D,F,D...; each rvalid one cycle after its grant.
REQ-033 Data port alone, addresses 0x0..0x3 in consecutive cycles -> four consecutive data_rvalid pulses, in order, with data mem[0]..mem[3].
REQ-034 reset_n driven low in the cycle after a fetch grant -> fetch_rvalid=0 immediately; no rvalid after release; first contended grant goes to fetch.
REQ-035 No requests for 5 cycles -> no gnt, no rvalid, prio unchanged.
REQ-036 LOADER_EN: load 0xDEADBEEF to 0x020 with fetch_req high -> load_gnt=1, mem_wren=1, fetch_gnt=0; fetch granted next cycle; a later fetch of 0x020 returns 0xDEADBEEF.
